tx_word_serializer: RTL and testbench
=====================================

Name: tx_word_serializer

Overview:
- Transmit-side companion to the ISERDES/IDELAY receive path.
- Runs on clk160 and accepts 32-bit words over a valid/ready handshake.
- Emits one 8-bit parallel byte per clk160 cycle to an 8:1 OSERDESE3 clocked by clk640/clk160.
- Inserts idle words when starved, sends a training pattern for far-end delay alignment, and supports a programmable bit-slip so the far end can be frame-aligned.

Parameters:
- IDLE_WORD, 32'hACACACAC, word sent when no data is available in normal mode.
- TRAIN_BYTE, 8'hF0, byte repeated every cycle in training mode.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk160  input  1  byte clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_data  input  32  word to send; byte [31:24] goes out first.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  word is accepted on a cycle where s_valid && s_ready.
- train_mode  input  1  1 = send training pattern, 0 = normal.
- bit_slip  input  3  output bit rotation, 0..7.
- tx_byte  output  8  parallel byte to the OSERDES D input; bit 7 is transmitted first.
- word_strobe  output  1  tx_byte is the first byte of a word (frame marker, for debug).
- in_training  output  1  the word currently being sent is training.
- words_sent  output  CNT_WIDTH  count of data words sent; saturates.
- idles_sent  output  CNT_WIDTH  count of idle words sent; saturates.
- reset_counters  input  1  synchronous clear of both counters.

Behaviour:
- Reset (reset=1): state=IDLE, byte_cnt=0, shift register=IDLE_WORD, prev_byte=0. Outputs: tx_byte=0, s_ready=0, word_strobe=0, in_training=0, counters=0.
- byte_cnt is a 2-bit counter that increments every cycle and wraps 3->0. A word boundary is the cycle with byte_cnt==3.
- States are IDLE, DATA and TRAIN. The state is re-evaluated only at word boundaries, so a word is never truncated.
  - At the boundary, train_mode=1 -> TRAIN.
  - Otherwise, s_valid=1 -> DATA: load s_data.
  - Otherwise -> IDLE: load IDLE_WORD.
- s_ready = (byte_cnt==3) && !train_mode && !reset. It is combinational from registered state and train_mode.
- s_data is ignored whenever s_ready=0. Holding s_valid for several cycles does not cause a double accept.
- Shift register: the word is loaded at the boundary. The following 4 cycles present bytes [31:24], [23:16], [15:8], [7:0] as pre_byte.
- TRAIN: pre_byte=TRAIN_BYTE in every cycle.
- Bit-slip stage:
  - Register pre_byte into cur; prev_byte <= cur.
  - tx_byte <= ({prev_byte,cur} >> bit_slip)[7:0].
  - bit_slip=0 gives tx_byte=cur.
  - A change to bit_slip takes effect on the next registered output. The stream is not flushed; one corrupted byte at the switch is allowed.
- Latency: a word accepted in cycle t has its first byte on tx_byte in cycle t+3 (bit_slip=0). word_strobe and in_training are aligned to that byte.
- Counters:
  - words_sent increments once per DATA word loaded; idles_sent increments once per IDLE word loaded.
  - Both saturate at all-ones.
  - reset_counters has priority over an increment in the same cycle.
- train_mode deasserting mid-word: TRAIN completes the current 4-byte slot, then normal selection resumes.

Optional Feature:
- Macro TX_PRBS_TRAIN_EN.
- Defined: TRAIN sends PRBS7 (x^7+x^6+1) in place of TRAIN_BYTE. The LFSR advances 8 bits per cycle, MSB first. It is seeded to 7'h7F on reset and on every entry to TRAIN, so the first training byte is 8'hFE.
- Undefined: TRAIN_BYTE is used and no LFSR logic is synthesised.

Test Plan:
- Reset, then idle for 16 cycles -> tx_byte repeats 8'hAC; word_strobe every 4th cycle; idles_sent=4; s_ready pulses only at byte_cnt==3.
- Hold s_valid=1 with s_data=32'h12345678 accepted at cycle t -> tx_byte 12,34,56,78 at t+3..t+6; words_sent=1; no double accept.
- Back-to-back words 32'hDEADBEEF, 32'h00FF00FF -> 8 contiguous bytes with no idle gap; idles_sent unchanged.
- Steady TRAIN_BYTE F0 with bit_slip stepped 0->1->4 -> tx_byte F0, then 78, then 0F.
- Assert train_mode mid data word -> that word finishes intact, then F0 (or FE... under TX_PRBS_TRAIN_EN) is sent. Deassert it -> data resumes on the next boundary.
- Preload both counters to all-ones -> they hold at saturation. reset_counters together with an increment -> both read 0 on the next cycle.

Source files
------------

// File: rtl/tx_word_serializer.sv
// rtl/tx_word_serializer.sv - 32-bit word to 8-bit OSERDES byte serializer with idle fill, training and bit-slip
// Optional macro TX_PRBS_TRAIN_EN: training sends PRBS7 instead of TRAIN_BYTE.
module tx_word_serializer #(
  parameter logic [31:0] IDLE_WORD  = 32'hACACACAC,
  parameter logic [7:0]  TRAIN_BYTE = 8'hF0,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk160,
  input  logic                 reset,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 train_mode,
  input  logic [2:0]           bit_slip,
  output logic [7:0]           tx_byte,
  output logic                 word_strobe,
  output logic                 in_training,
  output logic [CNT_WIDTH-1:0] words_sent,
  output logic [CNT_WIDTH-1:0] idles_sent,
  input  logic                 reset_counters
);

  typedef enum logic [1:0] {IDLE, DATA, TRAIN} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_reg;
  logic        boundary;
  logic [7:0]  pre_byte;
  logic [7:0]  train_byte;
  logic [7:0]  cur_byte;
  logic [7:0]  prev_byte;
  logic [15:0] slipped;
  logic        strobe_d1;
  logic        train_d1;
  logic        word_inc;
  logic        idle_inc;

  assign boundary = (byte_cnt == 2'd3);
  assign s_ready  = boundary && !train_mode && !reset;

  always_comb begin
    state_next = state;
    if (boundary) begin
      if (train_mode)   state_next = TRAIN;
      else if (s_valid) state_next = DATA;
      else              state_next = IDLE;
    end
  end

  always_ff @(posedge clk160) begin
    if (reset) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      shift_reg <= IDLE_WORD;
    end else begin
      state    <= state_next;
      byte_cnt <= byte_cnt + 2'd1;
      if (boundary)
        shift_reg <= (state_next == DATA) ? s_data : IDLE_WORD;
      else
        shift_reg <= {shift_reg[23:0], 8'h00};
    end
  end

`ifdef TX_PRBS_TRAIN_EN
  logic [6:0] lfsr;
  logic [6:0] lfsr_next;
  logic [6:0] lfsr_work;

  // Eight PRBS7 steps per byte clock; the oldest bit lands in tx bit 7.
  always_comb begin
    lfsr_work  = lfsr;
    train_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      train_byte[7-i] = lfsr_work[6];
      lfsr_work       = {lfsr_work[5:0], lfsr_work[6] ^ lfsr_work[5]};
    end
    lfsr_next = lfsr_work;
  end

  always_ff @(posedge clk160) begin
    if (reset)
      lfsr <= 7'h7F;
    else if (boundary && state_next == TRAIN && state != TRAIN)
      lfsr <= 7'h7F;
    else if (state == TRAIN)
      lfsr <= lfsr_next;
  end
`else
  assign train_byte = TRAIN_BYTE;
`endif

  assign pre_byte = (state == TRAIN) ? train_byte : shift_reg[31:24];
  assign slipped  = {prev_byte, cur_byte} >> bit_slip;

  // Output pipeline: pre_byte -> cur_byte -> tx_byte; frame flags follow the same two stages.
  always_ff @(posedge clk160) begin
    if (reset) begin
      cur_byte    <= 8'h00;
      prev_byte   <= 8'h00;
      tx_byte     <= 8'h00;
      strobe_d1   <= 1'b0;
      word_strobe <= 1'b0;
      train_d1    <= 1'b0;
      in_training <= 1'b0;
    end else begin
      cur_byte    <= pre_byte;
      prev_byte   <= cur_byte;
      tx_byte     <= slipped[7:0];
      strobe_d1   <= (byte_cnt == 2'd0);
      word_strobe <= strobe_d1;
      train_d1    <= (state == TRAIN);
      in_training <= train_d1;
    end
  end

  assign word_inc = boundary && (state_next == DATA);
  assign idle_inc = boundary && (state_next == IDLE);

  always_ff @(posedge clk160) begin
    if (reset || reset_counters) begin
      words_sent <= '0;
      idles_sent <= '0;
    end else begin
      if (word_inc && words_sent != {CNT_WIDTH{1'b1}})
        words_sent <= words_sent + 1'b1;
      if (idle_inc && idles_sent != {CNT_WIDTH{1'b1}})
        idles_sent <= idles_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_word_serializer.sv
// tb/tb_tx_word_serializer.sv - directed self-checking bench for tx_word_serializer
module tb_tx_word_serializer;

  logic        clk160 = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        train_mode;
  logic [2:0]  bit_slip;
  logic [7:0]  tx_byte;
  logic        word_strobe;
  logic        in_training;
  logic [15:0] words_sent;
  logic [15:0] idles_sent;
  logic        reset_counters;

  logic        s_valid2;
  logic        s_ready2;
  logic [7:0]  tx_byte2;
  logic        word_strobe2;
  logic        in_training2;
  logic [2:0]  words_sent2;
  logic [2:0]  idles_sent2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef TX_PRBS_TRAIN_EN
  localparam logic [7:0] FIRST_TRAIN = 8'hFE;
`else
  localparam logic [7:0] FIRST_TRAIN = 8'hF0;
`endif

  always #3 clk160 = ~clk160;

  tx_word_serializer dut (
    .clk160(clk160), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .train_mode(train_mode), .bit_slip(bit_slip), .tx_byte(tx_byte), .word_strobe(word_strobe),
    .in_training(in_training), .words_sent(words_sent), .idles_sent(idles_sent),
    .reset_counters(reset_counters)
  );

  // Narrow-counter instance so saturation is reachable in a few dozen cycles.
  tx_word_serializer #(.CNT_WIDTH(3)) u_sat (
    .clk160(clk160), .reset(reset), .s_data(32'h55AA55AA), .s_valid(s_valid2), .s_ready(s_ready2),
    .train_mode(1'b0), .bit_slip(3'd0), .tx_byte(tx_byte2), .word_strobe(word_strobe2),
    .in_training(in_training2), .words_sent(words_sent2), .idles_sent(idles_sent2),
    .reset_counters(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk160);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  logic [7:0] b2b [8];

  initial begin
    b2b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    reset = 1'b1; s_data = 32'h0; s_valid = 1'b0; train_mode = 1'b0;
    bit_slip = 3'd0; reset_counters = 1'b0; s_valid2 = 1'b1;

    repeat (3) step();
    chk("ready_in_reset", 32'(s_ready), 32'h0);
    reset = 1'b0;
    cyc = 0;

    chk("rst_tx", 32'(tx_byte), 32'h0);
    chk("rst_strobe", 32'(word_strobe), 32'h0);
    chk("rst_train", 32'(in_training), 32'h0);
    chk("rst_words", 32'(words_sent), 32'h0);
    chk("rst_idles", 32'(idles_sent), 32'h0);

    for (int k = 0; k < 16; k++) begin
      chk("idle_tx", 32'(tx_byte), (k < 2) ? 32'h0 : 32'hAC);
      chk("idle_strobe", 32'(word_strobe), (k >= 2 && (k % 4) == 2) ? 32'h1 : 32'h0);
      chk("idle_ready", 32'(s_ready), ((k % 4) == 3) ? 32'h1 : 32'h0);
      step();
    end
    chk("idles_after16", 32'(idles_sent), 32'd4);
    chk("words_after16", 32'(words_sent), 32'd0);

    s_valid = 1'b1; s_data = 32'h12345678;
    goto(19);
    chk("accept_ready", 32'(s_ready), 32'h1);
    goto(20);
    s_valid = 1'b0;
    chk("words_one", 32'(words_sent), 32'd1);
    goto(22);
    chk("w1_b0", 32'(tx_byte), 32'h12);
    chk("w1_strobe", 32'(word_strobe), 32'h1);
    goto(23);
    chk("w1_b1", 32'(tx_byte), 32'h34);
    chk("w1_nostrobe", 32'(word_strobe), 32'h0);
    goto(24);
    chk("w1_b2", 32'(tx_byte), 32'h56);
    chk("no_double_accept", 32'(words_sent), 32'd1);
    chk("idles_five", 32'(idles_sent), 32'd5);
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    goto(25);
    chk("w1_b3", 32'(tx_byte), 32'h78);
    goto(28);
    s_data = 32'h00FF00FF;
    goto(30);
    for (int k = 0; k < 8; k++) begin
      chk("b2b_byte", 32'(tx_byte), 32'(b2b[k]));
      if (cyc == 32) begin
        s_valid = 1'b0;
        chk("b2b_idles", 32'(idles_sent), 32'd5);
        chk("b2b_words", 32'(words_sent), 32'd3);
      end
      step();
    end
    goto(36);
    chk("idles_six", 32'(idles_sent), 32'd6);
    s_valid = 1'b1; s_data = 32'h11223344;
    goto(40);
    s_valid = 1'b0;
    chk("sat_words", 32'(words_sent2), 32'd7);
    s_valid2 = 1'b0;
    goto(41);
    train_mode = 1'b1;
    goto(42);
    chk("w3_b0", 32'(tx_byte), 32'h11);
    chk("w3_notrain", 32'(in_training), 32'h0);
    goto(43);
    chk("train_blocks_ready", 32'(s_ready), 32'h0);
    goto(44);
    chk("words_four", 32'(words_sent), 32'd4);
    goto(45);
    chk("w3_b3", 32'(tx_byte), 32'h44);
    chk("w3_b3_notrain", 32'(in_training), 32'h0);
    goto(46);
    chk("train_first", 32'(tx_byte), 32'(FIRST_TRAIN));
    chk("train_flag", 32'(in_training), 32'h1);
    chk("train_strobe", 32'(word_strobe), 32'h1);

    goto(50);
`ifndef TX_PRBS_TRAIN_EN
    chk("slip0", 32'(tx_byte), 32'hF0);
    bit_slip = 3'd1;
    step();
    chk("slip1", 32'(tx_byte), 32'h78);
    bit_slip = 3'd4;
    step();
    chk("slip4", 32'(tx_byte), 32'h0F);
    bit_slip = 3'd0;
    step();
    chk("slip_back0", 32'(tx_byte), 32'hF0);
`endif
    goto(53);
    train_mode = 1'b0; s_valid = 1'b1; s_data = 32'hCAFEF00D;
    goto(55);
    chk("resume_ready", 32'(s_ready), 32'h1);
    goto(56);
    s_valid = 1'b0;
    goto(57);
    chk("last_train_flag", 32'(in_training), 32'h1);
    goto(58);
    chk("resume_b0", 32'(tx_byte), 32'hCA);
    chk("resume_notrain", 32'(in_training), 32'h0);
    chk("resume_strobe", 32'(word_strobe), 32'h1);
    goto(59);
    chk("words_five", 32'(words_sent), 32'd5);
    chk("idles_pre_clr", 32'(idles_sent), 32'd6);
    reset_counters = 1'b1;
    goto(60);
    reset_counters = 1'b0;
    chk("clr_words", 32'(words_sent), 32'd0);
    chk("clr_idles", 32'(idles_sent), 32'd0);
    goto(61);
    chk("resume_b3", 32'(tx_byte), 32'h0D);
    goto(76);
    chk("sat_idles", 32'(idles_sent2), 32'd7);
    chk("sat_words_hold", 32'(words_sent2), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
